matrix_multiplier_v3: RTL and testbench

Parametrised, pipelined successor to the current matrix multiplier for the DFR readout path. It computes Z = X × Y over external single-port RAMs, with X, Y and Z all stored row-major. It issues one X/Y read pair per cycle, tolerates a configurable RAM read latency, and accumulates in a wide register. Each result is rescaled and saturated to fixed point, and the block writes one Z word per output element.

---
 rtl/matrix_multiplier_v3.sv | 184 ++++++++++++++++++
 tb/tb_matrix_multiplier_v3.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_multiplier_v3.sv
// matrix_multiplier_v3: Z = X * Y over external row-major RAMs.
// One X/Y read pair per cycle, wide accumulate, rescale and saturate.
module matrix_multiplier_v3 #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ACC_WIDTH   = 64,
    parameter int FRAC_BITS   = 0,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [ADDR_WIDTH-1:0] x_rows,
    input  logic [ADDR_WIDTH-1:0] y_cols,
    input  logic [ADDR_WIDTH-1:0] x_cols_y_rows,
    input  logic [DATA_WIDTH-1:0] x_data,
    input  logic [DATA_WIDTH-1:0] y_data,
    output logic [ADDR_WIDTH-1:0] x_addr,
    output logic [ADDR_WIDTH-1:0] y_addr,
    output logic [ADDR_WIDTH-1:0] z_addr,
    output logic [DATA_WIDTH-1:0] z_data,
    output logic                  z_wen,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WRITE,
        FINISH
    } state_t;

    state_t state, state_n;

    logic [ADDR_WIDTH-1:0] m_q, n_q, k_q;
    logic [ADDR_WIDTH-1:0] i_q, j_q, k_cnt, x_base;
    logic [2:0]            d_cnt;
    logic                  signed_q;
    logic [RAM_LATENCY-1:0] vld;
    logic [ACC_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0] z_hold;

    logic dims_ok, k_last, drain_last, last_el;

    assign dims_ok    = (|x_rows) && (|y_cols) && (|x_cols_y_rows);
    assign k_last     = (k_cnt == k_q - ADDR_WIDTH'(1));
    assign drain_last = (d_cnt == 3'(RAM_LATENCY - 1));
    assign last_el    = (i_q == m_q - ADDR_WIDTH'(1)) &&
                        (j_q == n_q - ADDR_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = dims_ok ? ISSUE : FINISH;
            ISSUE:   if (k_last) state_n = DRAIN;
            DRAIN:   if (drain_last) state_n = WRITE;
            WRITE:   state_n = last_el ? FINISH : ISSUE;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operands are extended before the multiply so one product serves both modes
    logic [2*DATA_WIDTH-1:0] xe, ye, prod;
    logic [ACC_WIDTH-1:0]    prod_ext;

    always_comb begin
        if (signed_q) begin
            xe = {{DATA_WIDTH{x_data[DATA_WIDTH-1]}}, x_data};
            ye = {{DATA_WIDTH{y_data[DATA_WIDTH-1]}}, y_data};
        end else begin
            xe = {{DATA_WIDTH{1'b0}}, x_data};
            ye = {{DATA_WIDTH{1'b0}}, y_data};
        end
        prod = xe * ye;
        if (signed_q) prod_ext = ACC_WIDTH'($signed(prod));
        else          prod_ext = ACC_WIDTH'(prod);
    end

    logic [ACC_WIDTH-1:0]  sh;
    logic [DATA_WIDTH-1:0] sat;

    always_comb begin
        if (signed_q) begin
            sh = $signed(acc) >>> FRAC_BITS;
            if ((&sh[ACC_WIDTH-1:DATA_WIDTH-1]) ||
                !(|sh[ACC_WIDTH-1:DATA_WIDTH-1]))
                sat = sh[DATA_WIDTH-1:0];
            else
                sat = {sh[ACC_WIDTH-1], {(DATA_WIDTH-1){~sh[ACC_WIDTH-1]}}};
        end else begin
            sh = acc >> FRAC_BITS;
            if (|sh[ACC_WIDTH-1:DATA_WIDTH]) sat = '1;
            else                             sat = sh[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_cnt    <= '0;
            x_base   <= '0;
            d_cnt    <= '0;
            signed_q <= 1'b0;
            vld      <= '0;
            acc      <= '0;
            z_hold   <= '0;
            x_addr   <= '0;
            y_addr   <= '0;
            z_addr   <= '0;
        end else begin
            vld[0] <= (state == ISSUE);
            for (int p = 1; p < RAM_LATENCY; p++) vld[p] <= vld[p-1];
            if (vld[RAM_LATENCY-1]) acc <= acc + prod_ext;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m_q      <= x_rows;
                        n_q      <= y_cols;
                        k_q      <= x_cols_y_rows;
                        signed_q <= signed_mode;
                        i_q      <= '0;
                        j_q      <= '0;
                        k_cnt    <= '0;
                        x_base   <= '0;
                        z_addr   <= '0;
                        if (dims_ok) begin
                            x_addr <= '0;
                            y_addr <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (k_cnt == '0) acc <= '0;
                    if (k_last) begin
                        k_cnt <= '0;
                        d_cnt <= '0;
                    end else begin
                        k_cnt  <= k_cnt + ADDR_WIDTH'(1);
                        x_addr <= x_addr + ADDR_WIDTH'(1);
                        y_addr <= y_addr + n_q;
                    end
                end
                DRAIN: d_cnt <= d_cnt + 3'd1;
                WRITE: begin
                    z_hold <= sat;
                    z_addr <= z_addr + ADDR_WIDTH'(1);
                    if (!last_el) begin
                        if (j_q == n_q - ADDR_WIDTH'(1)) begin
                            j_q    <= '0;
                            i_q    <= i_q + ADDR_WIDTH'(1);
                            x_base <= x_base + k_q;
                            x_addr <= x_base + k_q;
                            y_addr <= '0;
                        end else begin
                            j_q    <= j_q + ADDR_WIDTH'(1);
                            x_addr <= x_base;
                            y_addr <= j_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign z_wen  = (state == WRITE);
    assign busy   = (state == ISSUE) || (state == DRAIN) || (state == WRITE);
    assign done   = (state == FINISH);
    assign z_data = z_wen ? sat : z_hold;

endmodule

// File: tb/tb_matrix_multiplier_v3.sv
// Bench for matrix_multiplier_v3: three instances (latency 1, latency 3,
// 16 fractional bits) driven from vector tables and random jobs.
module tb_matrix_multiplier_v3;

    localparam int NI = 3;

    function automatic int lat_of(input int g);
        return (g == 1) ? 3 : 1;
    endfunction

    function automatic int frac_of(input int g);
        return (g == 2) ? 16 : 0;
    endfunction

    typedef struct {
        int          g;
        int          m;
        int          n;
        int          k;
        bit          sgn;
        logic [31:0] x [9];
        logic [31:0] y [9];
        logic [31:0] z [4];
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start_s [NI];
    logic        sgn_s   [NI];
    logic [31:0] xr [NI];
    logic [31:0] yc [NI];
    logic [31:0] kd [NI];
    logic [31:0] xd [NI];
    logic [31:0] yd [NI];
    logic [31:0] xa [NI];
    logic [31:0] ya [NI];
    logic [31:0] za [NI];
    logic [31:0] zd [NI];
    logic        zw [NI];
    logic        bz [NI];
    logic        dn [NI];

    logic [31:0] xm [NI][64];
    logic [31:0] ym [NI][64];
    logic [31:0] xv [64];
    logic [31:0] yv [64];
    logic [31:0] exp_z [16];

    wr_t wq [$];
    int  busy_cnt [NI];
    int  done_cnt [NI];
    int  done_cyc [NI];
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;

    vec_t vt [9];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [31:0] px [4];
        logic [31:0] py [4];
        always @(posedge clk) begin
            px[0] <= xm[g][xa[g][5:0]];
            py[0] <= ym[g][ya[g][5:0]];
            for (int i = 1; i < 4; i++) begin
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end
        end
        assign xd[g] = px[lat_of(g)-1];
        assign yd[g] = py[lat_of(g)-1];

        matrix_multiplier_v3 #(
            .RAM_LATENCY(lat_of(g)),
            .FRAC_BITS  (frac_of(g))
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start_s[g]),
            .signed_mode  (sgn_s[g]),
            .x_rows       (xr[g]),
            .y_cols       (yc[g]),
            .x_cols_y_rows(kd[g]),
            .x_data       (xd[g]),
            .y_data       (yd[g]),
            .x_addr       (xa[g]),
            .y_addr       (ya[g]),
            .z_addr       (za[g]),
            .z_data       (zd[g]),
            .z_wen        (zw[g]),
            .busy         (bz[g]),
            .done         (dn[g])
        );
    end

    always @(negedge clk) begin
        wr_t w;
        for (int g = 0; g < NI; g++) begin
            if (zw[g] === 1'b1) begin
                w.a = za[g];
                w.d = zd[g];
                w.c = cyc;
                wq.push_back(w);
            end
            if (dn[g] === 1'b1) begin
                done_cnt[g] = done_cnt[g] + 1;
                done_cyc[g] = cyc;
            end
            if (bz[g] === 1'b1) busy_cnt[g] = busy_cnt[g] + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, want);
        end
    endtask

    // Reference: plain dot product, 64-bit wrap, shift, clamp to range
    function automatic logic [31:0] model(input int i, input int j,
                                          input int n, input int k,
                                          input bit sgn, input int frac);
        logic [63:0] acc;
        logic [63:0] u;
        longint      s;
        acc = '0;
        for (int t = 0; t < k; t++) begin
            if (sgn)
                acc += longint'($signed(xv[i*k+t])) *
                       longint'($signed(yv[t*n+j]));
            else
                acc += {32'd0, xv[i*k+t]} * {32'd0, yv[t*n+j]};
        end
        if (sgn) begin
            s = $signed(acc) >>> frac;
            if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
            if (s < -64'sd2147483648) return 32'h8000_0000;
            return s[31:0];
        end
        u = acc >> frac;
        if (u > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
        return u[31:0];
    endfunction

    task automatic load_mem(input int g);
        for (int i = 0; i < 64; i++) begin
            xm[g][i] = xv[i];
            ym[g][i] = yv[i];
        end
    endtask

    task automatic run_job(input int g, input int m, input int n,
                           input int k, input bit sgn, input bit poke,
                           input bit fpoke, output int c0, output int w0,
                           output int b0, output int d0);
        load_mem(g);
        @(negedge clk);
        xr[g] = m;
        yc[g] = n;
        kd[g] = k;
        sgn_s[g] = sgn;
        start_s[g] = 1'b1;
        c0 = cyc;
        w0 = wq.size();
        b0 = busy_cnt[g];
        d0 = done_cnt[g];
        @(negedge clk);
        start_s[g] = 1'b0;
        if (poke) begin
            repeat (2) @(negedge clk);
            start_s[g] = 1'b1;
            xr[g] = m + 1;
            yc[g] = n + 1;
            kd[g] = k + 1;
            sgn_s[g] = ~sgn;
            @(negedge clk);
            start_s[g] = 1'b0;
        end
        for (int t = 0; t < 4000 && dn[g] !== 1'b1; t++) @(negedge clk);
        chk("done_seen", dn[g], 1);
        if (fpoke) start_s[g] = 1'b1;
        @(negedge clk);
        start_s[g] = 1'b0;
        repeat (3) @(negedge clk);
        xr[g] = m;
        yc[g] = n;
        kd[g] = k;
        sgn_s[g] = sgn;
    endtask

    task automatic check_job(input int g, input int m, input int n,
                             input int k, input int c0, input int w0,
                             input int b0, input int d0, input string nm);
        int p;
        int nw;
        p  = k + lat_of(g) + 1;
        nw = wq.size() - w0;
        chk({nm, ".writes"}, nw, m * n);
        for (int e = 0; e < m * n && e < nw; e++) begin
            chk($sformatf("%s.z%0d.addr", nm, e), wq[w0+e].a, e);
            chk($sformatf("%s.z%0d.data", nm, e), wq[w0+e].d, exp_z[e]);
            chk($sformatf("%s.z%0d.cyc", nm, e), wq[w0+e].c,
                c0 + 1 + k + lat_of(g) + e * p);
        end
        chk({nm, ".done_cnt"}, done_cnt[g] - d0, 1);
        chk({nm, ".done_cyc"}, done_cyc[g], c0 + 1 + m * n * p);
        chk({nm, ".busy_cyc"}, busy_cnt[g] - b0, m * n * p);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        vec_t v;
        int   c0, w0, b0, d0;
        int   g, m, n, k;
        bit   sgn, big;

        vt[0] = '{0, 2, 2, 2, 1'b0, '{1, 2, 3, 4, 0, 0, 0, 0, 0},
                  '{5, 6, 7, 8, 0, 0, 0, 0, 0}, '{19, 22, 43, 50}};
        vt[1] = '{0, 1, 1, 3, 1'b1, '{-1, 2, -3, 0, 0, 0, 0, 0, 0},
                  '{4, -5, 6, 0, 0, 0, 0, 0, 0}, '{32'hFFFF_FFE0, 0, 0, 0}};
        vt[2] = '{2, 1, 1, 1, 1'b1, '{32'h7FFF_0000, 0, 0, 0, 0, 0, 0, 0, 0},
                  '{32'h0002_0000, 0, 0, 0, 0, 0, 0, 0, 0},
                  '{32'h7FFF_FFFF, 0, 0, 0}};
        vt[3] = '{2, 1, 1, 1, 1'b1, '{32'h0001_8000, 0, 0, 0, 0, 0, 0, 0, 0},
                  '{32'h0002_0000, 0, 0, 0, 0, 0, 0, 0, 0},
                  '{32'h0003_0000, 0, 0, 0}};
        vt[4] = '{2, 1, 1, 1, 1'b1, '{32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0},
                  '{32'h0002_0000, 0, 0, 0, 0, 0, 0, 0, 0},
                  '{32'h8000_0000, 0, 0, 0}};
        vt[5] = '{2, 1, 1, 1, 1'b0, '{32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0},
                  '{32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0},
                  '{32'hFFFF_FFFF, 0, 0, 0}};
        vt[6] = '{1, 2, 2, 2, 1'b0, '{1, 0, 0, 1, 0, 0, 0, 0, 0},
                  '{9, 8, 7, 6, 0, 0, 0, 0, 0}, '{9, 8, 7, 6}};
        vt[7] = '{0, 2, 1, 3, 1'b0, '{1, 2, 3, 4, 5, 6, 0, 0, 0},
                  '{1, 1, 1, 0, 0, 0, 0, 0, 0}, '{6, 15, 0, 0}};
        vt[8] = '{0, 1, 3, 2, 1'b1, '{2, -1, 0, 0, 0, 0, 0, 0, 0},
                  '{1, 2, 3, 4, 5, 6, 0, 0, 0},
                  '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0}};

        for (int i = 0; i < NI; i++) begin
            start_s[i] = 1'b0;
            sgn_s[i]   = 1'b0;
            xr[i] = '0;
            yc[i] = '0;
            kd[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset%0d.ctl", i), {zw[i], bz[i], dn[i]}, 0);
            chk($sformatf("reset%0d.addr", i), {xa[i], ya[i]}, 0);
            chk($sformatf("reset%0d.zout", i), {za[i], zd[i]}, 0);
        end
        rst = 1'b0;

        for (int t = 0; t < 9; t++) begin
            v = vt[t];
            for (int i = 0; i < 64; i++) begin
                xv[i] = (i < 9) ? v.x[i] : 32'd0;
                yv[i] = (i < 9) ? v.y[i] : 32'd0;
            end
            for (int e = 0; e < 4; e++) exp_z[e] = v.z[e];
            run_job(v.g, v.m, v.n, v.k, v.sgn, 1'b0, 1'b0, c0, w0, b0, d0);
            check_job(v.g, v.m, v.n, v.k, c0, w0, b0, d0,
                      $sformatf("vec%0d", t));
        end

        for (int r = 0; r < 12; r++) begin
            g   = r % NI;
            m   = $urandom_range(1, 3);
            n   = $urandom_range(1, 3);
            k   = $urandom_range(1, 3);
            sgn = 1'($urandom_range(0, 1));
            big = (r >= 6);
            for (int i = 0; i < 64; i++) begin
                xv[i] = big ? $urandom : ($urandom_range(0, 511) - 32'd256);
                yv[i] = big ? $urandom : ($urandom_range(0, 511) - 32'd256);
            end
            for (int e = 0; e < m * n; e++)
                exp_z[e] = model(e / n, e % n, n, k, sgn, frac_of(g));
            run_job(g, m, n, k, sgn, 1'b0, 1'b0, c0, w0, b0, d0);
            check_job(g, m, n, k, c0, w0, b0, d0, $sformatf("rnd%0d", r));
        end

        // Reset in the middle of a 2x2 job, then a clean rerun
        for (int i = 0; i < 64; i++) begin
            xv[i] = (i < 4) ? 32'(i + 1) : 32'd0;
            yv[i] = (i < 4) ? 32'(i + 5) : 32'd0;
        end
        load_mem(0);
        @(negedge clk);
        xr[0] = 2;
        yc[0] = 2;
        kd[0] = 2;
        sgn_s[0] = 1'b0;
        start_s[0] = 1'b1;
        w0 = wq.size();
        d0 = done_cnt[0];
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int t = 0; t < 100 && (wq.size() - w0) < 2; t++)
            @(negedge clk);
        chk("midrst.two_writes", wq.size() - w0, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.ctl", {zw[0], bz[0], dn[0]}, 0);
        chk("midrst.addr", {xa[0], ya[0]}, 0);
        chk("midrst.zout", {za[0], zd[0]}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst.no_writes", wq.size() - w0, 2);
        chk("midrst.no_done", done_cnt[0] - d0, 0);

        exp_z[0] = 19;
        exp_z[1] = 22;
        exp_z[2] = 43;
        exp_z[3] = 50;
        run_job(0, 2, 2, 2, 1'b0, 1'b1, 1'b1, c0, w0, b0, d0);
        check_job(0, 2, 2, 2, c0, w0, b0, d0, "restart");

        run_job(0, 0, 2, 2, 1'b0, 1'b0, 1'b0, c0, w0, b0, d0);
        chk("zero.writes", wq.size() - w0, 0);
        chk("zero.done_cnt", done_cnt[0] - d0, 1);
        chk("zero.done_cyc", done_cyc[0], c0 + 1);
        chk("zero.busy_cyc", busy_cnt[0] - b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
